// File: rtl/dma_word_unpacker_pkg.sv
// Shared definitions for the DMA-to-PS/2 word unpacker: state encoding and default sizing.
package dma_word_unpacker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int unsigned DEF_NUM_BYTES = 4;
  localparam int unsigned DEF_BYTE_W    = 8;
  localparam int unsigned DEF_CNT_W     = 3;

endpackage

// File: rtl/dma_word_unpacker_byte_shift_reg.sv
// Word-wide shift register: parallel load, shift left by one byte, top byte exposed.
// Optional PS2_PARITY_EN adds a registered odd-parity bit for the exposed byte.
module byte_shift_reg
  import dma_word_unpacker_pkg::*;
#(
  parameter int unsigned NUM_BYTES = DEF_NUM_BYTES,
  parameter int unsigned BYTE_W    = DEF_BYTE_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_load,
  input  logic                          i_shift,
  input  logic [NUM_BYTES*BYTE_W-1:0]   i_data,
`ifdef PS2_PARITY_EN
  output logic                          o_top_parity,
`endif
  output logic [BYTE_W-1:0]             o_top
);

  localparam int unsigned W = NUM_BYTES * BYTE_W;

  logic [W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= {r_data[W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    end
  end

  assign o_top = r_data[W-1 -: BYTE_W];

`ifdef PS2_PARITY_EN
  logic r_parity;

  // Parity is computed from whichever byte becomes the top byte next, so it stays aligned with o_top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b1;
    end else if (i_load) begin
      r_parity <= ~^i_data[W-1 -: BYTE_W];
    end else if (i_shift) begin
      r_parity <= ~^r_data[W-BYTE_W-1 -: BYTE_W];
    end
  end

  assign o_top_parity = r_parity;
`endif

endmodule

// File: rtl/dma_word_unpacker.sv
// Accepts one DMA word and emits it MSB byte first toward the PS/2 transmitter, pulsing listo at the end.
// Build option: define PS2_PARITY_EN to add the registered byte_parity output.
module dma_word_unpacker
  import dma_word_unpacker_pkg::*;
#(
  parameter int unsigned NUM_BYTES = DEF_NUM_BYTES,
  parameter int unsigned BYTE_W    = DEF_BYTE_W,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_BYTES*BYTE_W-1:0]   word_in,
  input  logic                          word_valid,
  output logic                          word_ready,
  output logic [BYTE_W-1:0]             byte_out,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic [CNT_W-1:0]              z,
`ifdef PS2_PARITY_EN
  output logic                          byte_parity,
`endif
  output logic                          busy,
  output logic                          listo
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_z;
  logic             r_word_ready;
  logic             r_byte_valid;
  logic             r_busy;
  logic             r_listo;

  logic w_load;
  logic w_shift;

  assign w_load  = (r_state == ST_IDLE) && word_valid;
  assign w_shift = (r_state == ST_SEND) && byte_ready;

  byte_shift_reg #(
    .NUM_BYTES (NUM_BYTES),
    .BYTE_W    (BYTE_W)
  ) u_shift (
    .clk          (clk),
    .rst          (reset),
    .i_load       (w_load),
    .i_shift      (w_shift),
    .i_data       (word_in),
`ifdef PS2_PARITY_EN
    .o_top_parity (byte_parity),
`endif
    .o_top        (byte_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_z          <= '0;
      r_word_ready <= 1'b1;
      r_byte_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_listo      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (word_valid) begin
            r_state      <= ST_SEND;
            r_z          <= '0;
            r_word_ready <= 1'b0;
            r_byte_valid <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        ST_SEND: begin
          if (byte_ready) begin
            r_z <= r_z + CNT_W'(1);
            if (r_z == LAST_IDX) begin
              r_state      <= ST_DONE;
              r_byte_valid <= 1'b0;
              r_listo      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_z          <= '0;
          r_listo      <= 1'b0;
          r_word_ready <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_z          <= '0;
          r_word_ready <= 1'b1;
          r_byte_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_listo      <= 1'b0;
        end
      endcase
    end
  end

  assign word_ready = r_word_ready;
  assign byte_valid = r_byte_valid;
  assign busy       = r_busy;
  assign listo      = r_listo;
  assign z          = r_z;

endmodule

// File: tb/tb_dma_word_unpacker.sv
// Self-checking bench for dma_word_unpacker: directed test-plan words plus random words with random backpressure.
module tb_dma_word_unpacker;

  localparam int unsigned NB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic [2:0]  z;
  logic        busy;
  logic        listo;
`ifdef PS2_PARITY_EN
  logic        byte_parity;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  dma_word_unpacker #(
    .NUM_BYTES (4),
    .BYTE_W    (8),
    .CNT_W     (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .z          (z),
`ifdef PS2_PARITY_EN
    .byte_parity(byte_parity),
`endif
    .busy       (busy),
    .listo      (listo)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: byte k of a word, most-significant byte first.
  function automatic logic [7:0] ref_byte(input logic [31:0] w, input int unsigned k);
    return 8'((w >> (8 * (NB - 1 - k))) & 32'hFF);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".word_ready"}, {31'd0, word_ready}, 32'd1);
    chk({tag, ".byte_valid"}, {31'd0, byte_valid}, 32'd0);
    chk({tag, ".busy"},       {31'd0, busy},       32'd0);
    chk({tag, ".listo"},      {31'd0, listo},      32'd0);
    chk({tag, ".z"},          {29'd0, z},          32'd0);
  endtask

  // Called one cycle after the accept edge; returns in IDLE after the listo cycle.
  task automatic expect_word(input logic [31:0] w, input int unsigned st_lo, input int unsigned st_hi);
    int unsigned stalls;
    logic [7:0] e;
    for (int unsigned k = 0; k < NB; k++) begin
      e = ref_byte(w, k);
      stalls = $urandom_range(st_hi, st_lo);
      for (int unsigned s = 0; s <= stalls; s++) begin
        byte_ready = (s == stalls);
        chk("send.byte_valid", {31'd0, byte_valid}, 32'd1);
        chk("send.byte_out",   {24'd0, byte_out},   {24'd0, e});
        chk("send.z",          {29'd0, z},          k);
        chk("send.word_ready", {31'd0, word_ready}, 32'd0);
        chk("send.busy",       {31'd0, busy},       32'd1);
        chk("send.listo",      {31'd0, listo},      32'd0);
`ifdef PS2_PARITY_EN
        chk("send.parity",     {31'd0, byte_parity}, {31'd0, ~^e});
`endif
        cycle();
      end
    end
    byte_ready = 1'b1;
    chk("done.listo",      {31'd0, listo},      32'd1);
    chk("done.z",          {29'd0, z},          NB);
    chk("done.byte_valid", {31'd0, byte_valid}, 32'd0);
    chk("done.word_ready", {31'd0, word_ready}, 32'd0);
    chk("done.busy",       {31'd0, busy},       32'd1);
    cycle();
    chk_idle("after");
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned st_lo, input int unsigned st_hi);
    word_in    = w;
    word_valid = 1'b1;
    cycle();
    word_valid = 1'b0;
    word_in    = $urandom;
    expect_word(w, st_lo, st_hi);
  endtask

  initial begin
    reset      = 1'b1;
    word_in    = '0;
    word_valid = 1'b0;
    byte_ready = 1'b0;
    cycle();
    cycle();
    chk_idle("reset");
    chk("reset.byte_out", {24'd0, byte_out}, 32'd0);
`ifdef PS2_PARITY_EN
    chk("reset.parity", {31'd0, byte_parity}, 32'd1);
`endif
    #2 reset = 1'b0;
    cycle();
    chk_idle("released");

    byte_ready = 1'b1;
    send_word(32'hA1B2C3D4, 0, 0);

    send_word(32'h12345678, 3, 3);

    // Word offered during SEND/DONE must be ignored until IDLE.
    word_in    = 32'h00000000;
    word_valid = 1'b1;
    cycle();
    word_in = 32'hFFFFFFFF;
    expect_word(32'h00000000, 0, 0);
    cycle();
    word_valid = 1'b0;
    expect_word(32'hFFFFFFFF, 0, 0);

    // Asynchronous reset after the second byte has been accepted.
    word_in    = 32'hCAFEBABE;
    word_valid = 1'b1;
    cycle();
    word_valid = 1'b0;
    chk("rst.b0", {24'd0, byte_out}, 32'hCA);
    cycle();
    chk("rst.b1", {24'd0, byte_out}, 32'hFE);
    cycle();
    chk("rst.z2", {29'd0, z}, 32'd2);
    #2 reset = 1'b1;
    #1;
    chk_idle("async_rst");
    chk("async_rst.byte_out", {24'd0, byte_out}, 32'd0);
    #2 reset = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      cycle();
      chk("post_rst.listo",      {31'd0, listo},      32'd0);
      chk("post_rst.byte_valid", {31'd0, byte_valid}, 32'd0);
    end
    send_word(32'h01020304, 0, 0);

    // Back-to-back words with word_valid held high.
    word_in    = 32'h11223344;
    word_valid = 1'b1;
    cycle();
    word_in = 32'h55667788;
    expect_word(32'h11223344, 0, 0);
    cycle();
    word_valid = 1'b0;
    expect_word(32'h55667788, 0, 0);

    send_word(32'h00FF0107, 0, 0);

    for (int unsigned n = 0; n < 12; n++) begin
      send_word($urandom, 0, 2);
      for (int unsigned g = $urandom_range(2, 0); g > 0; g--) begin
        byte_ready = 1'($urandom);
        cycle();
        chk_idle("gap");
      end
      byte_ready = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_word_unpacker.md
Name: dma_word_unpacker

Overview:
Transmit-direction counterpart of the keyboard receive buffer. It accepts one 32-bit word from the DMA module and emits it as four successive bytes toward the PS/2 host-to-device transmitter. Bytes go out most-significant first, so the word {b0,b1,b2,b3} is sent b0, b1, b2, b3. This matches the packing order used on the receive side. A one-cycle "listo" pulse marks completion of each word.

Parameters:
NUM_BYTES, 4, number of bytes per word (word width = NUM_BYTES*BYTE_W)
BYTE_W, 8, byte width in bits
CNT_W, 3, byte-counter width; must hold the value NUM_BYTES

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
word_in  input  NUM_BYTES*BYTE_W  word from DMA
word_valid  input  1  DMA presents word_in
word_ready  output  1  block can accept a word (high only in IDLE)
byte_out  output  BYTE_W  current byte toward the PS/2 transmitter
byte_valid  output  1  byte_out is valid
byte_ready  input  1  transmitter accepts byte_out this cycle
z  output  CNT_W  number of bytes already accepted in the current word (0..NUM_BYTES)
busy  output  1  high in SEND and DONE
listo  output  1  one-cycle pulse: all bytes of the word have been accepted

Behaviour:
- Reset (async assert, sync release): state=IDLE, shift register=0, z=0, byte_out=0, byte_valid=0, word_ready=1, busy=0, listo=0.
- States: IDLE, SEND, DONE.
- IDLE:
  - word_ready=1, byte_valid=0.
  - If word_valid=1: capture word_in into the shift register, z<=0, go to SEND.
  - A word is accepted only when word_valid and word_ready are both high on the same edge.
- SEND:
  - byte_valid=1; byte_out = upper BYTE_W bits of the shift register (registered output, no combinational path from word_in).
  - If byte_ready=1: shift left by BYTE_W with zero fill, z<=z+1.
  - If the accepted byte was the last (z==NUM_BYTES-1 before increment), go to DONE; z then reads NUM_BYTES.
  - If byte_ready=0: hold byte_out, byte_valid and z unchanged. There is no timeout.
- DONE:
  - listo=1 for exactly this one cycle, byte_valid=0, word_ready=0.
  - Next cycle: IDLE, z<=0.
- Latency:
  - Word accept edge to first byte_valid: 1 cycle.
  - With byte_ready held at 1: NUM_BYTES cycles in SEND, then 1 cycle of listo.
  - Minimum word-to-word period: NUM_BYTES+2 cycles.
- word_valid in SEND or DONE is ignored (word_ready=0); DMA must hold the word until accepted.
- byte_ready while byte_valid=0 is ignored.
- Reset mid-word: the word is discarded immediately and asynchronously. No listo pulse, and no partial resume after release.
- word_in value 0 is sent like any other data; there is no special-casing.

Optional Feature:
PS2_PARITY_EN:
- When defined: adds output byte_parity (1 bit) = odd parity of byte_out, i.e. XNOR-reduce of byte_out. It is registered alongside byte_out and is 1 at reset, since odd parity of 0x00 is 1.
- When undefined: the port and its logic are absent; the transmitter computes parity itself.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, SEND=2'b01, DONE=2'b10), default NUM_BYTES/BYTE_W/CNT_W constants.
- One natural sub-module: byte_shift_reg. It provides parallel load, shift-left by BYTE_W on enable, async reset, and exposes the top byte. The FSM and counter remain in dma_word_unpacker.

Test Plan:
- Reset, then word_in=32'hA1B2C3D4 with word_valid=1 for 1 cycle and byte_ready=1 constant:
  - byte_out sequence A1, B2, C3, D4 on 4 consecutive cycles; z reads 0, 1, 2, 3 during those cycles.
  - listo=1 on the 6th cycle with z=4; word_ready=1 on the 7th.
- Backpressure, word 32'h12345678:
  - byte_ready low for 3 cycles at each byte: each byte is held stable while waiting, byte_valid stays 1, and z does not advance.
  - Output order is 12, 34, 56, 78.
- word_valid asserted with word 32'hFFFFFFFF during SEND of 32'h00000000:
  - Ignored; outputs 00, 00, 00, 00 then listo.
  - The second word is accepted only after returning to IDLE.
- Async reset pulsed after the 2nd byte of 32'hCAFEBABE:
  - Outputs return to reset values immediately (z=0, byte_valid=0, listo never pulses).
  - A following word 32'h01020304 is sent correctly.
- Back-to-back words 32'h11223344 and 32'h55667788 with word_valid held and byte_ready=1:
  - 8 bytes in order, with a 2-cycle gap between words and two listo pulses.
- With PS2_PARITY_EN, word 32'h00FF0107:
  - byte_parity sequence 1, 1, 0, 0.
